mersenne_sweep_scheduler: RTL

MERSENNE_SWEEP_SCHEDULER -- requirements
Module: mersenne_sweep_scheduler

---
 rtl/mersenne_pkg.sv | 32 +++
 rtl/mersenne_result_fifo.sv | 68 ++++++
 rtl/mersenne_sweep_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mersenne_pkg.sv
// ============================================================================
// Module   : mersenne_pkg
// Purpose  : Shared widths, FSM state encoding and result record for the
//            Mersenne exponent sweep scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mersenne_pkg;

  localparam int EXP_W = 8;
  localparam int CYC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SIEVE = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_PUSH  = 3'd4,
    S_NEXT  = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  typedef struct packed {
    logic [EXP_W-1:0] exponent;
    logic             is_prime;
    logic [CYC_W-1:0] cycles;
  } result_t;

endpackage

`default_nettype wire

// File: rtl/mersenne_result_fifo.sv
// ============================================================================
// Module   : mersenne_result_fifo
// Purpose  : Synchronous FIFO of tester results; head is visible while not
//            empty, a pop advances it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mersenne_result_fifo
  import mersenne_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  result_t wdata_i,
  input  logic    pop_i,
  output result_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  result_t         mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     count_q;
  logic            w_wr;
  logic            w_rd;

  assign full_o  = (count_q == C_FULL_CNT);
  assign empty_o = (count_q == '0);
  assign w_wr    = push_i & ~full_o;
  assign w_rd    = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_wr) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (w_rd) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mersenne_sweep_scheduler.sv
// ============================================================================
// Module   : mersenne_sweep_scheduler
// Purpose  : Walks an exponent range, optionally sieves it, drives an external
//            prime tester and queues its verdicts. Option: MERSENNE_SIEVE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mersenne_sweep_scheduler
  import mersenne_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [EXP_W-1:0] cfg_p_lo,
  input  logic [EXP_W-1:0] cfg_p_hi,
  output logic             tst_start,
  output logic [EXP_W-1:0] tst_exponent,
  input  logic             tst_done,
  input  logic             tst_is_prime,
  input  logic [CYC_W-1:0] tst_cycles,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [EXP_W-1:0] res_exponent,
  output logic             res_is_prime,
  output logic [CYC_W-1:0] res_cycles,
  output logic             busy,
  output logic             sweep_done,
  output logic [EXP_W-1:0] tested_count
);

  state_e           state_q, state_d;
  // One bit wider than an exponent so that stepping past 255 cannot wrap.
  logic [EXP_W:0]   p_q, p_d;
  logic [EXP_W-1:0] hi_q, hi_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             prime_q, prime_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [EXP_W:0]   w_p_next;

`ifdef MERSENNE_SIEVE_EN
  logic [4:0]       d_q, d_d;
  logic [EXP_W:0]   rem_q, rem_d;
  logic [9:0]       w_dd;

  assign w_dd = {5'd0, d_q} * {5'd0, d_q};
`endif

  result_t w_wdata;
  result_t w_head;
  logic    w_full;
  logic    w_empty;
  logic    w_push;

  assign w_p_next = p_q + 9'd1;
  assign w_push   = (state_q == S_PUSH) && !w_full;
  assign w_wdata  = '{exponent: p_q[EXP_W-1:0], is_prime: prime_q, cycles: cyc_q};

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    prime_d = prime_q;
    cyc_d   = cyc_q;
`ifdef MERSENNE_SIEVE_EN
    d_d     = d_q;
    rem_d   = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          p_d     = {1'b0, cfg_p_lo};
          hi_d    = cfg_p_hi;
          cnt_d   = '0;
          state_d = (cfg_p_lo > cfg_p_hi) ? S_FIN : S_SIEVE;
`ifdef MERSENNE_SIEVE_EN
          d_d     = 5'd2;
          rem_d   = {1'b0, cfg_p_lo};
`endif
        end
      end
      S_SIEVE: begin
`ifdef MERSENNE_SIEVE_EN
        // Trial division: one subtraction per cycle, next divisor once the
        // running remainder drops below the current one.
        if (p_q < 9'd2) begin
          state_d = S_NEXT;
        end else if (w_dd > {1'b0, p_q}) begin
          state_d = S_ISSUE;
        end else if (rem_q == '0) begin
          state_d = S_NEXT;
        end else if (rem_q < {4'd0, d_q}) begin
          d_d   = d_q + 5'd1;
          rem_d = p_q;
        end else begin
          rem_d = rem_q - {4'd0, d_q};
        end
`else
        state_d = S_ISSUE;
`endif
      end
      S_ISSUE: begin
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        first_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The first WAIT cycle may still see the previous test's done.
        first_d = 1'b0;
        if (!first_q && tst_done) begin
          prime_d = tst_is_prime;
          cyc_d   = tst_cycles;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!w_full) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_p_next > {1'b0, hi_q}) begin
          state_d = S_FIN;
        end else begin
          p_d     = w_p_next;
          state_d = S_SIEVE;
`ifdef MERSENNE_SIEVE_EN
          d_d     = 5'd2;
          rem_d   = w_p_next;
`endif
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      prime_q <= 1'b0;
      cyc_q   <= '0;
`ifdef MERSENNE_SIEVE_EN
      d_q     <= 5'd2;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      prime_q <= prime_d;
      cyc_q   <= cyc_d;
`ifdef MERSENNE_SIEVE_EN
      d_q     <= d_d;
      rem_q   <= rem_d;
`endif
    end
  end

  mersenne_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .wdata_i (w_wdata),
    .pop_i   (res_ready),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign cfg_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign tst_start    = (state_q == S_ISSUE);
  assign tst_exponent = p_q[EXP_W-1:0];
  assign sweep_done   = (state_q == S_FIN);
  assign tested_count = cnt_q;
  assign res_valid    = !w_empty;
  assign res_exponent = w_empty ? '0 : w_head.exponent;
  assign res_is_prime = w_empty ? 1'b0 : w_head.is_prime;
  assign res_cycles   = w_empty ? '0 : w_head.cycles;

endmodule

`default_nettype wire
